// File: rtl/uart_cmd_decode_pkg.sv
// Shared command codes and FSM encoding for the UART byte-stream command decoder.
package uart_cmd_decode_pkg;

  localparam logic [7:0] CMD_WR  = 8'h55;
  localparam logic [7:0] CMD_RD  = 8'hAA;
  localparam int unsigned TIMER_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/uart_cmd_decode.sv
// Decodes received UART bytes into write frames (buffered, then pushed to the
// SDRAM write FIFO in one burst) and read commands; partial frames time out.
module uart_cmd_decode
  import uart_cmd_decode_pkg::*;
#(
  parameter int unsigned WR_LEN  = 8,
  parameter int unsigned TIMEOUT = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       po_flag,
  output logic       wfifo_wr_en,
  output logic [7:0] wfifo_wr_data,
  output logic       wr_trig,
  output logic       rd_trig,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(WR_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WR_LEN);
  localparam logic [TIMER_W-1:0] TIMEOUT_V = TIMER_W'(TIMEOUT);
  localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

  state_t             state_r;
  state_t             state_next_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [CNT_W-1:0]   cnt_next_s;
  logic [TIMER_W-1:0] timer_r;
  logic [7:0]         buf_r [WR_LEN];
  logic [7:0]         pend_data_r;
  logic               pend_valid_r;

  logic               byte_vld_s;
  logic [7:0]         byte_s;
  logic               store_en_s;
  logic [7:0]         flush_byte_s;
  logic [7:0]         first_byte_s;
  logic               wr_en_next_s;
  logic [7:0]         wr_data_next_s;
  logic               wr_trig_next_s;
  logic               rd_trig_next_s;
  logic               frame_err_next_s;

  // A byte held over from FLUSH takes priority over the live strobe in IDLE.
  assign byte_vld_s   = pend_valid_r | po_flag;
  assign byte_s       = pend_valid_r ? pend_data_r : rx_data;
  // With a one-byte frame the first push is the byte arriving right now.
  assign first_byte_s = (WR_LEN == 1) ? rx_data : buf_r[0];

  // Buffer read mux for the FLUSH push index.
  always_comb begin
    flush_byte_s = 8'h00;
    for (int i = 0; i < int'(WR_LEN); i++) begin
      flush_byte_s = (cnt_r == CNT_W'(i)) ? buf_r[i] : flush_byte_s;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_next_s     = state_r;
    cnt_next_s       = cnt_r;
    store_en_s       = 1'b0;
    wr_en_next_s     = 1'b0;
    wr_data_next_s   = wfifo_wr_data;
    wr_trig_next_s   = 1'b0;
    rd_trig_next_s   = 1'b0;
    frame_err_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (byte_vld_s && (byte_s == CMD_WR)) begin
          state_next_s = COLLECT;
          cnt_next_s   = {CNT_W{1'b0}};
        end else if (byte_vld_s && (byte_s == CMD_RD)) begin
          rd_trig_next_s = 1'b1;
        end else begin
          state_next_s = IDLE;
        end
      end
      COLLECT: begin
        if (po_flag) begin
          store_en_s = 1'b1;
          if (cnt_r == CNT_LAST) begin
            state_next_s   = FLUSH;
            wr_en_next_s   = 1'b1;
            wr_data_next_s = first_byte_s;
            cnt_next_s     = CNT_W'(1);
          end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
          end
        end else if (timer_r >= TIMEOUT_V) begin
          state_next_s     = IDLE;
          frame_err_next_s = 1'b1;
          cnt_next_s       = {CNT_W{1'b0}};
        end else begin
          state_next_s = COLLECT;
        end
      end
      FLUSH: begin
        if (cnt_r == CNT_FULL) begin
          state_next_s   = IDLE;
          wr_trig_next_s = 1'b1;
          cnt_next_s     = {CNT_W{1'b0}};
        end else begin
          wr_en_next_s   = 1'b1;
          wr_data_next_s = flush_byte_s;
          cnt_next_s     = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // FSM state and byte/push counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Inter-byte idle timer: runs only while collecting, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= {TIMER_W{1'b0}};
    end else if ((state_r != COLLECT) || po_flag) begin
      timer_r <= {TIMER_W{1'b0}};
    end else if (timer_r != TIMER_MAX) begin
      timer_r <= timer_r + TIMER_W'(1);
    end
  end

  // Payload buffer, written at the current collect index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(WR_LEN); i++) begin
        buf_r[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < int'(WR_LEN); i++) begin
        if (store_en_s && (cnt_r == CNT_W'(i))) begin
          buf_r[i] <= rx_data;
        end
      end
    end
  end

  // Single-entry hold for a byte that lands while the burst is flushing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_data_r  <= 8'h00;
      pend_valid_r <= 1'b0;
    end else if ((state_r == FLUSH) && po_flag) begin
      pend_data_r  <= rx_data;
      pend_valid_r <= 1'b1;
    end else if (state_r == IDLE) begin
      pend_valid_r <= 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wfifo_wr_en   <= 1'b0;
      wfifo_wr_data <= 8'h00;
      wr_trig       <= 1'b0;
      rd_trig       <= 1'b0;
      frame_err     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      wfifo_wr_en   <= wr_en_next_s;
      wfifo_wr_data <= wr_data_next_s;
      wr_trig       <= wr_trig_next_s;
      rd_trig       <= rd_trig_next_s;
      frame_err     <= frame_err_next_s;
      busy          <= (state_next_s != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cmd_decode.sv
// Self-checking bench: byte-stream reference model predicts pushes/pulses by cycle.
module tb_uart_cmd_decode;

  localparam int WR_LEN  = 8;
  localparam int TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       po_flag = 1'b0;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_wr_data;
  logic       wr_trig;
  logic       rd_trig;
  logic       frame_err;
  logic       busy;

  uart_cmd_decode #(.WR_LEN(WR_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .po_flag(po_flag),
    .wfifo_wr_en(wfifo_wr_en), .wfifo_wr_data(wfifo_wr_data),
    .wr_trig(wr_trig), .rd_trig(rd_trig), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // observed events
  int         push_cyc_q[$];
  logic [7:0] push_dat_q[$];
  int         wr_q[$], rd_q[$], err_q[$];
  int         overlap = 0;
  // expected events
  int         exp_push_cyc_q[$];
  logic [7:0] exp_push_dat_q[$];
  int         exp_wr_q[$], exp_rd_q[$], exp_err_q[$];
  // reference model state
  bit         m_in = 1'b0;
  logic [7:0] m_pay[$];
  int         m_last = 0;
  logic [7:0] fr_q[$];

  always @(negedge clk) begin
    if (wfifo_wr_en) begin
      push_cyc_q.push_back(cyc);
      push_dat_q.push_back(wfifo_wr_data);
      if (wr_trig) overlap++;
    end
    if (wr_trig)   wr_q.push_back(cyc);
    if (rd_trig)   rd_q.push_back(cyc);
    if (frame_err) err_q.push_back(cyc);
    if ((int'(wr_trig) + int'(rd_trig) + int'(frame_err)) > 1) overlap++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_timeout_upto(input int c);
    if (m_in && (c - m_last - 1 > TIMEOUT)) begin
      exp_err_q.push_back(m_last + TIMEOUT + 2);
      m_in = 1'b0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    model_timeout_upto(c);
    if (!m_in) begin
      if (b == 8'h55) begin
        m_in = 1'b1;
        m_pay.delete();
        m_last = c;
      end else if (b == 8'hAA) begin
        exp_rd_q.push_back(c + 1);
      end
    end else begin
      m_pay.push_back(b);
      m_last = c;
      if (m_pay.size() == WR_LEN) begin
        for (int i = 0; i < WR_LEN; i++) begin
          exp_push_cyc_q.push_back(c + 1 + i);
          exp_push_dat_q.push_back(m_pay[i]);
        end
        exp_wr_q.push_back(c + WR_LEN + 1);
        m_in = 1'b0;
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) step();
    rx_data = b;
    po_flag = 1'b1;
    model_byte(b, cyc);
    step();
    po_flag = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic drive_raw(input logic [7:0] b);
    rx_data = b;
    po_flag = 1'b1;
    step();
    po_flag = 1'b0;
  endtask

  // boundary_idx selects which payload byte follows a gap of exactly TIMEOUT idle cycles
  task automatic send_frame(input int boundary_idx);
    send(8'h55, 1);
    for (int i = 0; i < fr_q.size(); i++)
      send(fr_q[i], (i == boundary_idx) ? TIMEOUT : int'($urandom_range(0, 3)));
    repeat (WR_LEN + 1) step();
  endtask

  task automatic clear_obs();
    push_cyc_q.delete(); push_dat_q.delete();
    wr_q.delete(); rd_q.delete(); err_q.delete();
  endtask

  task automatic compare_all(input string tag);
    repeat (TIMEOUT + WR_LEN + 4) step();
    model_timeout_upto(cyc);
    check({tag, "_npush"}, 32'(push_cyc_q.size()), 32'(exp_push_cyc_q.size()));
    for (int i = 0; i < push_cyc_q.size() && i < exp_push_cyc_q.size(); i++) begin
      check({tag, "_push_cyc"}, 32'(push_cyc_q[i]), 32'(exp_push_cyc_q[i]));
      check({tag, "_push_dat"}, 32'(push_dat_q[i]), 32'(exp_push_dat_q[i]));
    end
    check({tag, "_nwr"}, 32'(wr_q.size()), 32'(exp_wr_q.size()));
    for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++)
      check({tag, "_wr_cyc"}, 32'(wr_q[i]), 32'(exp_wr_q[i]));
    check({tag, "_nrd"}, 32'(rd_q.size()), 32'(exp_rd_q.size()));
    for (int i = 0; i < rd_q.size() && i < exp_rd_q.size(); i++)
      check({tag, "_rd_cyc"}, 32'(rd_q[i]), 32'(exp_rd_q[i]));
    check({tag, "_nerr"}, 32'(err_q.size()), 32'(exp_err_q.size()));
    for (int i = 0; i < err_q.size() && i < exp_err_q.size(); i++)
      check({tag, "_err_cyc"}, 32'(err_q[i]), 32'(exp_err_q[i]));
    check({tag, "_busy_idle"}, 32'(busy), 32'd0);
    clear_obs();
    exp_push_cyc_q.delete(); exp_push_dat_q.delete();
    exp_wr_q.delete(); exp_rd_q.delete(); exp_err_q.delete();
  endtask

  initial begin
    int c0;
    int kind;
    int k;
    logic [7:0] b;

    // reset values
    repeat (3) step();
    check("rst_wr_en",   32'(wfifo_wr_en),   32'd0);
    check("rst_wr_data", 32'(wfifo_wr_data), 32'd0);
    check("rst_wr_trig", 32'(wr_trig),       32'd0);
    check("rst_rd_trig", 32'(rd_trig),       32'd0);
    check("rst_ferr",    32'(frame_err),     32'd0);
    check("rst_busy",    32'(busy),          32'd0);
    rst = 1'b0;
    step();

    // read command
    send(8'hAA, 2);
    compare_all("rd");

    // incrementing write frame, with busy observed mid-frame
    send(8'h55, 1);
    check("busy_collect", 32'(busy), 32'd1);
    for (int i = 1; i <= WR_LEN; i++) send(8'(i), 0);
    check("busy_flush", 32'(busy), 32'd1);
    repeat (WR_LEN + 1) step();
    compare_all("wr_inc");

    // partial frame times out, then a read still works
    send(8'h55, 1);
    send(8'h11, 0);
    send(8'h22, 0);
    repeat (TIMEOUT + 2) step();
    send(8'hAA, 0);
    compare_all("timeout");

    // stray bytes, then frame of command-looking payload
    send(8'h00, 1);
    send(8'hFF, 1);
    send(8'h3C, 1);
    fr_q.delete();
    for (int i = 0; i < WR_LEN; i++) fr_q.push_back(8'hAA);
    send_frame(-1);
    compare_all("stray_aa");

    // byte on the exact timeout cycle wins (after header and mid-payload)
    fr_q.delete();
    for (int i = 0; i < WR_LEN; i++) fr_q.push_back(8'(8'h40 + i));
    send_frame(0);
    send_frame(WR_LEN - 1);
    compare_all("boundary");

    // randomized transaction mix
    for (int t = 0; t < 40; t++) begin
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: send(8'hAA, int'($urandom_range(0, 3)));
        1: begin
          b = 8'($urandom);
          if (b == 8'h55 || b == 8'hAA) b = b ^ 8'h01;
          send(b, int'($urandom_range(0, 3)));
        end
        2: begin
          fr_q.delete();
          for (int i = 0; i < WR_LEN; i++) fr_q.push_back(8'($urandom));
          send_frame(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WR_LEN - 1)) : -1);
        end
        default: begin
          k = int'($urandom_range(0, WR_LEN - 1));
          send(8'h55, 1);
          for (int i = 0; i < k; i++) send(8'($urandom), int'($urandom_range(0, 3)));
          repeat (TIMEOUT + 1 + int'($urandom_range(0, 2))) step();
        end
      endcase
    end
    compare_all("random");

    // byte arriving during FLUSH is held and served once back in IDLE
    drive_raw(8'h55);
    for (int i = 0; i < WR_LEN; i++) drive_raw(8'(8'h90 + i));
    c0 = cyc - 1;
    step();
    drive_raw(8'hAA);
    repeat (WR_LEN + 4) step();
    check("pend_npush", 32'(push_cyc_q.size()), 32'(WR_LEN));
    check("pend_wr_cyc", 32'((wr_q.size() > 0) ? wr_q[0] : -1), 32'(c0 + WR_LEN + 1));
    check("pend_rd_cyc", 32'((rd_q.size() > 0) ? rd_q[0] : -1), 32'(c0 + WR_LEN + 2));
    clear_obs();

    // reset during FLUSH after three pushes
    drive_raw(8'h55);
    for (int i = 0; i < WR_LEN; i++) drive_raw(8'(8'hC0 + i));
    step();
    step();
    step();
    rst = 1'b1;
    #2;
    check("rstf_wr_en", 32'(wfifo_wr_en), 32'd0);
    check("rstf_busy",  32'(busy),        32'd0);
    step();
    step();
    rst = 1'b0;
    repeat (2 * WR_LEN) step();
    check("rstf_npush", 32'(push_cyc_q.size()), 32'd3);
    check("rstf_dat2",  32'((push_dat_q.size() > 2) ? push_dat_q[2] : 8'h00), 32'hC2);
    check("rstf_nwr",   32'(wr_q.size()), 32'd0);
    clear_obs();

    // fresh frame after reset
    fr_q.delete();
    for (int i = 0; i < WR_LEN; i++) fr_q.push_back(8'($urandom));
    send_frame(-1);
    compare_all("post_rst");

    check("no_overlap", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
